// File: rtl/axil_uart_master.sv
// AXI4-Lite master that bridges a byte-in / byte-out stream pair onto a register-mapped UART.
// TX bytes become single writes; RX bytes are fetched by a status poll, a data read and a pop write.
module axil_uart_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 16
) (
    input  logic        m_axi_aclk,
    input  logic        reset,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        err
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0, TX_AW  = 4'd1, TX_B  = 4'd2, ST_AR  = 4'd3, ST_R    = 4'd4,
        DT_AR   = 4'd5, DT_R   = 4'd6, POP_AW = 4'd7, POP_B = 4'd8, RX_HOLD = 4'd9
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] awaddr_r, awaddr_s, wdata_r, wdata_s, araddr_r, araddr_s;
    logic        awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
    logic        arvalid_r, arvalid_s, rready_r, rready_s;
    logic [7:0]  rx_data_r, rx_data_s;
    logic        rx_valid_r, rx_valid_s, err_r, err_s, last_srv_r, last_srv_s, rd_bad_r, rd_bad_s;
    logic [15:0] poll_cnt_r, poll_cnt_s;
    logic        aw_left_s, w_left_s;
    logic        poll_due_s, tx_sel_s;
    logic        unused_rdata_s;

    // last_srv_r = 1 means the TX path was served most recently
    assign poll_due_s = (poll_cnt_r == 16'd0);
    assign tx_sel_s   = tx_valid && (!poll_due_s || !last_srv_r);

    // Combinational so the byte handshake can complete in the cycle tx_valid is seen
    assign tx_ready = !reset && (state_r == IDLE) && tx_sel_s;

    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = 4'b0001;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign err           = err_r;
    assign unused_rdata_s = ^m_axi_rdata[31:8];

    // Next-state and next-output computation for every registered signal
    always_comb begin
        state_s    = state_r;
        awaddr_s   = awaddr_r;
        wdata_s    = wdata_r;
        araddr_s   = araddr_r;
        awvalid_s  = awvalid_r;
        wvalid_s   = wvalid_r;
        bready_s   = bready_r;
        arvalid_s  = arvalid_r;
        rready_s   = rready_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = rx_valid_r;
        last_srv_s = last_srv_r;
        rd_bad_s   = rd_bad_r;
        aw_left_s  = 1'b0;
        w_left_s   = 1'b0;
        poll_cnt_s = poll_due_s ? 16'd0 : (poll_cnt_r - 16'd1);
        err_s      = err_r
                   | (m_axi_bvalid && bready_r && (m_axi_bresp != 2'b00))
                   | (m_axi_rvalid && rready_r && (m_axi_rresp != 2'b00));
        case (state_r)
            IDLE: begin
                if (tx_sel_s) begin
                    state_s    = TX_AW;
                    awaddr_s   = BASE_ADDR;
                    wdata_s    = {24'd0, tx_data};
                    awvalid_s  = 1'b1;
                    wvalid_s   = 1'b1;
                    last_srv_s = 1'b1;
                end else if (poll_due_s) begin
                    state_s    = ST_AR;
                    araddr_s   = BASE_ADDR + 32'h0000_0008;
                    arvalid_s  = 1'b1;
                    last_srv_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            TX_AW, POP_AW: begin
                // AW and W retire independently; leave only once both have gone
                aw_left_s = awvalid_r && !m_axi_awready;
                w_left_s  = wvalid_r && !m_axi_wready;
                awvalid_s = aw_left_s;
                wvalid_s  = w_left_s;
                if (!aw_left_s && !w_left_s) begin
                    state_s  = (state_r == TX_AW) ? TX_B : POP_B;
                    bready_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            TX_B: begin
                if (m_axi_bvalid) begin
                    bready_s = 1'b0;
                    state_s  = IDLE;
                end else begin
                    state_s = TX_B;
                end
            end
            ST_AR, DT_AR: begin
                if (m_axi_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = (state_r == ST_AR) ? ST_R : DT_R;
                end else begin
                    state_s = state_r;
                end
            end
            ST_R: begin
                if (m_axi_rvalid) begin
                    rready_s = 1'b0;
                    if (m_axi_rdata[0] || (m_axi_rresp != 2'b00)) begin
                        poll_cnt_s = 16'(POLL_GAP);
                        state_s    = IDLE;
                    end else begin
                        state_s   = DT_AR;
                        araddr_s  = BASE_ADDR + 32'h0000_0004;
                        arvalid_s = 1'b1;
                    end
                end else begin
                    state_s = ST_R;
                end
            end
            DT_R: begin
                if (m_axi_rvalid) begin
                    rready_s  = 1'b0;
                    rx_data_s = m_axi_rdata[7:0];
                    rd_bad_s  = (m_axi_rresp != 2'b00);
                    state_s   = POP_AW;
                    awaddr_s  = BASE_ADDR + 32'h0000_000C;
                    wdata_s   = 32'h0000_0001;
                    awvalid_s = 1'b1;
                    wvalid_s  = 1'b1;
                end else begin
                    state_s = DT_R;
                end
            end
            POP_B: begin
                if (m_axi_bvalid) begin
                    bready_s   = 1'b0;
                    poll_cnt_s = 16'd0;
                    if (!rd_bad_r) begin
                        rx_valid_s = 1'b1;
                        state_s    = RX_HOLD;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = POP_B;
                end
            end
            RX_HOLD: begin
                if (rx_ready) begin
                    rx_valid_s = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = RX_HOLD;
                end
            end
            default: begin
                state_s   = IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
                bready_s  = 1'b0;
                rready_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge m_axi_aclk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            awaddr_r   <= 32'd0;
            wdata_r    <= 32'd0;
            araddr_r   <= 32'd0;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            err_r      <= 1'b0;
            last_srv_r <= 1'b0;
            rd_bad_r   <= 1'b0;
            poll_cnt_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            awaddr_r   <= awaddr_s;
            wdata_r    <= wdata_s;
            araddr_r   <= araddr_s;
            awvalid_r  <= awvalid_s;
            wvalid_r   <= wvalid_s;
            bready_r   <= bready_s;
            arvalid_r  <= arvalid_s;
            rready_r   <= rready_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
            err_r      <= err_s;
            last_srv_r <= last_srv_s;
            rd_bad_r   <= rd_bad_s;
            poll_cnt_r <= poll_cnt_s;
        end
    end
endmodule

// File: doc/axil_uart_master.md
AXIL_UART_MASTER -- requirements
Module: axil_uart_master

Interface
REQ-001 BASE_ADDR, 32'h0000_0000, base address of the UART bridge register window.
REQ-002 POLL_GAP, 16, idle cycles between status polls after a poll returns RX-empty; legal range 1..65535.
REQ-003 m_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tx_data  in  8  byte to transmit; tx_valid  in  1; tx_ready  out  1 (valid/ready byte-in handshake).
REQ-006 rx_data  out  8  received byte; rx_valid  out  1; rx_ready  in  1 (valid/ready byte-out handshake).
REQ-007 m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1, m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1: AXI4-Lite write channels, master side.
REQ-008 m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1: AXI4-Lite read channels, master side.
REQ-009 err  out  1  sticky flag: any BRESP or RRESP != 2'b00 seen since reset.

Function
REQ-010 Target register map (offsets from BASE_ADDR): 0x00 write TX byte (wdata[7:0]); 0x04 read RX FIFO head (rdata[7:0]); 0x08 read status (bit0 = rx_empty, bit1 = rx_full); 0x0C write wdata[0] = 1 to pop the RX FIFO.
REQ-011 FSM states: IDLE, TX_AW (AW+W), TX_B, ST_AR, ST_R, DT_AR, DT_R, POP_AW (AW+W), POP_B, RX_HOLD.
REQ-012 Every write asserts awvalid and wvalid in the same cycle. Each valid drops independently in the cycle after its own ready is sampled high. Exit to the B state occurs once both handshakes complete.
REQ-013 Valid/address/data outputs are held stable until the matching ready is sampled. No new transaction is issued before the previous response handshake completes (one outstanding transaction).
REQ-014 bready = 1 exactly in TX_B/POP_B; rready = 1 exactly in ST_R/DT_R; response is consumed on the cycle valid && ready.
REQ-015 m_axi_wstrb = 4'b0001 for all writes; wdata[31:8] = 0.
REQ-016 tx_ready = 1 only in IDLE when the TX path is selected (REQ-017). On tx_valid && tx_ready, tx_data is latched; next cycle: TX_AW with awaddr = BASE_ADDR+0x00, wdata[7:0] = latched byte.
REQ-017 poll_due = (poll_cnt == 0). In IDLE with tx_valid && poll_due, the path not served last is taken (last_srv flag toggles per service). With only one candidate, that one is taken. With neither, stay in IDLE.
REQ-018 poll_cnt decrements by 1 per cycle while nonzero, saturating at 0, in every state.
REQ-019 Poll: ST_AR araddr = BASE_ADDR+0x08. On R: if rdata[0] = 1 or RRESP != OKAY, load poll_cnt = POLL_GAP and go to IDLE; else go to DT_AR.
REQ-020 Data: DT_AR araddr = BASE_ADDR+0x04. rdata[7:0] is captured into rx_data; a flag is kept if RRESP != OKAY. Then POP_AW: awaddr = BASE_ADDR+0x0C, wdata = 32'h1.
REQ-021 After POP_B: if the data read was OKAY, go to RX_HOLD; else discard the byte and go to IDLE. poll_cnt = 0 in both cases, so the next poll is immediate.
REQ-022 RX_HOLD: rx_valid = 1, rx_data stable. On rx_ready = 1, rx_valid = 0 next cycle and the FSM returns to IDLE. No TX or poll activity occurs in RX_HOLD (backpressure stalls the block).
REQ-023 err is set on any B or R handshake with resp != 2'b00; it is never cleared except by reset.
REQ-024 TX writes are fire-and-forget: BRESP only affects err. There is no TX-full check.

Reset
REQ-025 While reset = 1, all of the following are 0 regardless of clock: all AXI valid/ready outputs, tx_ready, rx_valid, rx_data, err, poll_cnt, last_srv (TX served first). State = IDLE; awaddr/araddr/wdata = 0.
REQ-026 Reset asserted mid-transaction aborts it immediately with no completion. After release, the first action is a status poll, or a TX if tx_valid is high (REQ-017).

Verification
REQ-027 tx_valid=1, tx_data=8'h5A, slave ready after 2 cycles -> awaddr=BASE+0x00 and wdata=32'h0000005A with wstrb=4'b0001, one write, tx_ready pulses once, err=0.
REQ-028 Slave status read returns 32'h1 (empty) -> no 0x04 read; next 0x08 read is issued no earlier than POLL_GAP=16 cycles later.
REQ-029 Status 32'h0, data read 32'h000000C3 -> write 0x0C with wdata=32'h1, then rx_valid=1 with rx_data=8'hC3; holding rx_ready=0 for 10 cycles keeps rx_valid high with no AXI traffic.
REQ-030 tx_valid held high while RX data is always available -> AXI sequence alternates TX write and poll/read/pop; neither path starves.
REQ-031 Slave returns RRESP=2'b10 on the 0x04 read -> pop still issued, rx_valid stays 0, err=1 and stays 1 until reset.
REQ-032 Reset asserted while awvalid=1 and awready=0 -> awvalid=0 asynchronously; after release, a poll of 0x08 is issued and completes normally.
